id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline stage that sits directly downstream of the opcode decoder. It registers the decoded control bundle (branch, regdst, alusrc, regwrite, memread, memreg, memwrite, aluop) together with register indices and operands. It detects load-use hazards, stalling decode and inserting a bubble, and squashes its contents on a taken-branch flush. A valid/ready handshake governs both sides, and saturating counters record stall and flush activity.

## Interface
- DATA_W, 16, operand and immediate width
- REG_W, 3, register index width; register 0 is hard-wired zero and never creates a hazard
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle (combinational)
- id_branch, id_regdst, id_alusrc, id_regwrite, id_memread, id_memreg, id_memwrite  in  1 each  decoded control
- id_aluop  in  3  decoded ALU op
- id_rs, id_rt, id_rd  in  REG_W  register indices
- id_rs_data, id_rt_data, id_imm  in  DATA_W  operands, sign-extended immediate
- flush  in  1  taken branch resolved downstream; squash
- ex_ready  in  1  execute stage accepts
- ex_valid  out  1  register holds a live instruction
- ex_branch, ex_regdst, ex_alusrc, ex_regwrite, ex_memread, ex_memreg, ex_memwrite  out  1 each  registered control
- ex_aluop  out  3  registered ALU op
- ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_dst  out  REG_W  registered destination: rd if regdst else rt
- hazard  out  1  load-use stall active (combinational)
- stall_cnt  out  16  saturating count of hazard cycles
- flush_cnt  out  8  saturating count of flush cycles

## Operation
- Reset: ex_valid=0, all ex_ control and aluop=0, ex_dst=0, ex_*_data/ex_imm=0, stall_cnt=0, flush_cnt=0.
- advance = ~ex_valid | ex_ready.
- uses_rt = ~id_alusrc | id_memwrite (R-type, branch, store).
- hazard = id_valid & ex_valid & ex_memread & (ex_dst≠0) & ((ex_dst==id_rs) | (uses_rt & ex_dst==id_rt)) & ~flush.
- id_ready = flush | (advance & ~hazard).
- Priority per cycle, highest first:
  - flush: ex_valid←0 and all ex_ control←0. The decode instruction is consumed and dropped. flush_cnt+1 (saturates at 255).
  - advance & hazard: bubble. ex_valid←0, control←0, data fields hold. stall_cnt+1.
  - advance & id_valid: capture all id_ fields, ex_valid←1, ex_dst←(id_regdst ? id_rd : id_rt).
  - advance & ~id_valid: ex_valid←0, control←0.
  - ~advance: all ex_ outputs hold. If hazard is also true, stall_cnt+1.
- Control fields are zero whenever ex_valid=0, so downstream never writes a register or memory from a bubble.
- stall_cnt saturates at 65535. Neither counter wraps.

## Timing
- Latency: 1 cycle from id_valid&id_ready to ex_valid.
- hazard, id_ready: combinational from id_ inputs, flush, ex_ready and registered state. No combinational path from id_ data inputs to ex_ outputs.
- Load-use bubble is exactly 1 cycle when ex_ready=1. The load advances, the bubble enters, the hazard clears, and the dependent instruction is captured on the next edge.
- With ex_ready=0 and a hazard present, the hazard persists until the load is accepted. Each of those cycles counts.
- flush and hazard in the same cycle: flush wins. hazard is forced 0 and stall_cnt does not increment.
- flush while ex_ready=0: the register is squashed anyway. The execute stage treats the flush as killing its input.
- rst_n asserted mid-operation: outputs go to reset values immediately (asynchronous). Deassertion is synchronised externally.

## Test plan
- Back-to-back R-type instructions: id_valid=1 with opcode-0 control (regdst=1, regwrite=1, aluop=4), rs=1, rt=2, rd=3, ex_ready=1 -> ex_valid=1 one cycle later, ex_dst=3, ex_aluop=4, no hazard, throughput 1 per cycle.
- Load-use: load (memread=1, regdst=0, rt=5) followed by R-type with rs=5 -> hazard=1 and id_ready=0 for 1 cycle, one bubble with all controls 0, dependent instruction captured next, stall_cnt=1. Repeat with dependent rt=5 on a store -> same result. Repeat with a dependent load using rt=5 as destination only -> no hazard.
- Destination 0: load with rt=0 followed by a use of rs=0 -> hazard=0, stall_cnt unchanged.
- Backpressure: ex_ready=0 for 3 cycles with a load held and a dependent instruction in decode -> ex_ outputs stable, id_ready=0, stall_cnt=3. Then ex_ready=1 -> bubble, then the dependent instruction advances.
- Flush: flush=1 coincident with a hazard -> next cycle ex_valid=0, controls 0, flush_cnt=1, stall_cnt unchanged, id_ready=1. Drive flush for 300 cycles -> flush_cnt saturates at 255.
- Reset mid-stream: assert rst_n=0 while ex_valid=1 and counters are non-zero -> all outputs zero without waiting for a clock edge. After release, the first accepted instruction behaves normally.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: one-cycle capture of decoded control and operands, with load-use bubbles and flush squash.
// Backpressure: id_ready drops while a load-use hazard is pending or while a live op is refused by ex_ready.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic              id_branch,
    input  logic              id_regdst,
    input  logic              id_alusrc,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memreg,
    input  logic              id_memwrite,
    input  logic [2:0]        id_aluop,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic              ex_branch,
    output logic              ex_regdst,
    output logic              ex_alusrc,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memreg,
    output logic              ex_memwrite,
    output logic [2:0]        ex_aluop,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [REG_W-1:0]  ex_dst,
    output logic              hazard,
    output logic [15:0]       stall_cnt,
    output logic [7:0]        flush_cnt
);
    typedef struct packed {
        logic       branch;
        logic       regdst;
        logic       alusrc;
        logic       regwrite;
        logic       memread;
        logic       memreg;
        logic       memwrite;
        logic [2:0] aluop;
    } ctrl_t;

    ctrl_t             ctrl_q;
    ctrl_t             id_ctrl;
    logic              valid_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_W-1:0]  dst_q;
    logic [15:0]       stall_q;
    logic [7:0]        flush_q;
    logic              advance;
    logic              uses_rt;
    logic              dst_hit;

    assign id_ctrl = {id_branch, id_regdst, id_alusrc, id_regwrite,
                      id_memread, id_memreg, id_memwrite, id_aluop};

    // rt is a source for R-type, branches and stores; loads only write it.
    assign uses_rt  = ~id_alusrc | id_memwrite;
    assign dst_hit  = (dst_q == id_rs) | (uses_rt & (dst_q == id_rt));
    assign advance  = ~valid_q | ex_ready;
    assign hazard   = id_valid & valid_q & ctrl_q.memread & (dst_q != '0) & dst_hit & ~flush;
    assign id_ready = flush | (advance & ~hazard);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            dst_q     <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end else if (advance) begin
                if (id_valid && !hazard) begin
                    valid_q   <= 1'b1;
                    ctrl_q    <= id_ctrl;
                    rs_data_q <= id_rs_data;
                    rt_data_q <= id_rt_data;
                    imm_q     <= id_imm;
                    dst_q     <= id_regdst ? id_rd : id_rt;
                end else begin
                    // Bubble or idle: controls cleared, operands left as they were.
                    valid_q <= 1'b0;
                    ctrl_q  <= '0;
                end
            end
            if (hazard && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush && (flush_q != 8'hFF)) begin
                flush_q <= flush_q + 8'd1;
            end
        end
    end

    assign ex_valid    = valid_q;
    assign ex_branch   = ctrl_q.branch;
    assign ex_regdst   = ctrl_q.regdst;
    assign ex_alusrc   = ctrl_q.alusrc;
    assign ex_regwrite = ctrl_q.regwrite;
    assign ex_memread  = ctrl_q.memread;
    assign ex_memreg   = ctrl_q.memreg;
    assign ex_memwrite = ctrl_q.memwrite;
    assign ex_aluop    = ctrl_q.aluop;
    assign ex_rs_data  = rs_data_q;
    assign ex_rt_data  = rt_data_q;
    assign ex_imm      = imm_q;
    assign ex_dst      = dst_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;
endmodule
